// File: rtl/bin_seg_pkg.sv
// Shared types and segment constants for the binary to seven-segment converter.
package bin_seg_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_ENC  = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_MINUS = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_0;
    endcase
  endfunction

  function automatic longint unsigned pow10(input int unsigned e);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin_seg_conv_seg_enc.sv
// Single-digit encoder: minus overrides blank, blank overrides the nibble code.
module seg_enc
  import bin_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       minus,
  output logic [7:0] seg
);

  always_comb begin
    if (minus)      seg = SEG_MINUS;
    else if (blank) seg = SEG_BLANK;
    else            seg = seg_of(nibble);
  end

endmodule

// File: rtl/bin_seg_conv.sv
// Sequential double-dabble binary to BCD conversion feeding N_DIG seven-segment encoders.
module bin_seg_conv
  import bin_seg_pkg::*;
#(
  parameter int unsigned           W       = 14,
  parameter int unsigned           N_DIG   = 4,
  parameter bit                    SIGNED  = 1'b0,
  parameter bit                    BLANK   = 1'b0,
  parameter logic [8*N_DIG-1:0]    ERR_PAT = 32'h763D507C
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         num,
  input  logic                 start,
  input  logic                 error,
  output logic [8*N_DIG-1:0]   digits,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned     SRW     = W + 4 * N_DIG;
  localparam int unsigned     CW      = $clog2(W + 1);
  localparam longint unsigned MAX_POS = pow10(N_DIG) - 1;
  localparam longint unsigned MAX_NEG = pow10(N_DIG - 1) - 1;

  state_e               state_q, state_d;
  logic [SRW-1:0]       sr_q, sr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 ovf_q, ovf_d;
  logic [8*N_DIG-1:0]   digits_q, digits_d;
  logic                 done_q, done_d;

  logic                 neg_in;
  logic [W-1:0]         mag;
  logic                 ovf_in;
  logic [SRW-1:0]       sr_step;
  logic [N_DIG-1:0]     lz, blank_v, minus_v;
  logic [8*N_DIG-1:0]   seg_v;

  always_comb begin
    neg_in = SIGNED && num[W-1];
    mag    = neg_in ? (~num + 1'b1) : num;
    ovf_in = neg_in ? (64'(mag) > MAX_NEG) : (64'(mag) > MAX_POS);
  end

  // One double-dabble step: correct every nibble >= 5, then shift left.
  always_comb begin
    sr_step = sr_q;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (sr_step[W+4*i +: 4] >= 4'd5)
        sr_step[W+4*i +: 4] = sr_step[W+4*i +: 4] + 4'd3;
    end
    sr_step = {sr_step[SRW-2:0], 1'b0};
  end

  // lz[g]: digits g and above are all zero; minus sits just above the top nonzero digit.
  for (genvar g = 0; g < N_DIG; g++) begin : g_dig
    assign lz[g] = (sr_q[SRW-1 : W+4*g] == '0);
    if (g == 0) begin : g_lsd
      assign minus_v[g] = 1'b0;
      assign blank_v[g] = 1'b0;
    end else begin : g_upper
      assign minus_v[g] = BLANK ? (neg_q && lz[g] && ((g == 1) || !lz[g-1]))
                                : (neg_q && (g == N_DIG - 1));
      assign blank_v[g] = BLANK && lz[g] && !minus_v[g];
    end
    seg_enc u_seg_enc (
      .nibble (sr_q[W+4*g +: 4]),
      .blank  (blank_v[g]),
      .minus  (minus_v[g]),
      .seg    (seg_v[8*g +: 8])
    );
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    digits_d = digits_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (error) begin
          state_d = S_ERR;
        end else if (start) begin
          sr_d    = {{(4*N_DIG){1'b0}}, mag};
          cnt_d   = '0;
          neg_d   = neg_in;
          ovf_d   = ovf_in;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (error) begin
          state_d = S_ERR;
        end else begin
          sr_d  = sr_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) state_d = S_ENC;
        end
      end
      S_ENC: begin
        digits_d = ovf_q ? ERR_PAT : seg_v;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        digits_d = ERR_PAT;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      digits_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      digits_q <= digits_d;
      done_q   <= done_d;
    end
  end

  assign digits = digits_q;
  assign done   = done_q;
  assign busy   = (state_q == S_CONV) || (state_q == S_ENC);

endmodule

// File: doc/bin_seg_conv.md
BIN_SEG_CONV -- requirements
Module: bin_seg_conv

Interface
REQ-001 The block SHALL have parameter W, default 14, meaning binary input width (4..32).
REQ-002 The block SHALL have parameter N_DIG, default 4, meaning number of seven-segment digits (2..8).
REQ-003 The block SHALL have parameter SIGNED, default 0, meaning num is two's complement when 1.
REQ-004 The block SHALL have parameter BLANK, default 0, meaning leading-zero digits are shown blank when 1.
REQ-005 The block SHALL have parameter ERR_PAT, width 8*N_DIG, default 32'h763D507C, meaning the error display pattern.
REQ-006 The block SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 num  in  W  value to convert, sampled only at start acceptance.
REQ-009 start  in  1  conversion request, level-sampled.
REQ-010 error  in  1  error request, level-sampled.
REQ-011 digits  out  8*N_DIG  segment codes, digit 0 (least significant) at [7:0]; bit 7 dp (always 0), bits 6..0 gfedcba.
REQ-012 busy  out  1  high while a conversion is in progress.
REQ-013 done  out  1  single-cycle pulse when digits has been updated.

Function
REQ-014 The FSM SHALL have states IDLE, CONV, ENC and ERR; any unused encoding SHALL return to IDLE on the next edge.
REQ-015 In IDLE, error=1 SHALL take priority over start and SHALL move to ERR on the next edge.
REQ-016 In IDLE, start=1 with error=0 SHALL capture num (or its magnitude when SIGNED=1 and num[W-1]=1), clear the BCD field, clear the step counter and enter CONV.
REQ-017 The shift register SHALL be W+4*N_DIG bits wide; the step counter SHALL be clog2(W+1) bits wide.
REQ-018 CONV SHALL perform exactly W double-dabble steps, one per clock: add 3 to every BCD nibble >=5, then shift left by 1.
REQ-019 After step W, the FSM SHALL enter ENC; ENC SHALL register digits, pulse done for one cycle and return to IDLE.
REQ-020 done SHALL be high in the cycle following the W+2nd rising edge after the start-sampling edge, counting that edge as edge 1.
REQ-021 busy SHALL be high in CONV and ENC and low otherwise; start SHALL be ignored while busy=1.
REQ-022 Overflow SHALL be detected at capture: magnitude > 10^N_DIG-1 (unsigned), or negative magnitude > 10^(N_DIG-1)-1 (signed); on overflow, ENC SHALL output ERR_PAT instead of digits.
REQ-023 When SIGNED=1 and the input is negative, the minus code 8'h40 SHALL occupy the digit immediately left of the most significant displayed digit; with BLANK=0 it SHALL occupy digit N_DIG-1.
REQ-024 When BLANK=1, zero digits above the most significant nonzero digit SHALL be 8'h00; digit 0 SHALL always be displayed (value 0 -> 8'h3F).
REQ-025 Segment codes for 0..9 SHALL be 3F,06,5B,4F,66,6D,7D,07,7F,6F; any other nibble SHALL encode as 3F.
REQ-026 ERR SHALL load digits=ERR_PAT, pulse done and return to IDLE one cycle after error was sampled.
REQ-027 error=1 sampled during CONV SHALL abort the conversion and enter ERR on the next edge; no conversion result SHALL be written.
REQ-028 digits SHALL hold its value between done pulses.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, digits=0, done=0 and busy=0, and SHALL clear the shift register and counter.
REQ-030 Reset asserted during CONV SHALL suppress the pending done; release SHALL resume in IDLE with no spurious pulse.

Structure
REQ-031 Package bin_seg_pkg SHALL hold the state enum, the segment constants (0..9, MINUS=8'h40, BLANK=8'h00) and the nibble-to-segment function.
REQ-032 One sub-module seg_enc SHALL map a 4-bit nibble, a blank flag and a minus flag to 8 segment bits; it SHALL be instanced N_DIG times by generate.

Verification
REQ-033 Defaults, num=1234, start pulse -> done 16 cycles later, digits=0x065B4F66, busy high for 15 cycles.
REQ-034 Defaults: num=9999 -> 0x6F6F6F6F; num=10000 -> 0x763D507C with a done pulse.
REQ-035 BLANK=1: num=7 -> 0x00000007; num=0 -> 0x0000003F.
REQ-036 SIGNED=1: num=-42 -> 0x403F665B (BLANK=0) and 0x0040665B (BLANK=1); num=-1000 -> ERR_PAT.
REQ-037 error and start high together in IDLE -> digits=0x763D507C, done one cycle later; error pulse at CONV step 5 -> ERR_PAT and a single done pulse.
REQ-038 rst_n low at CONV step 8 -> digits=0, busy=0 and done=0 immediately; no done pulse follows release.
